// File: rtl/j1_boot_loader.sv
// j1_boot_loader: loads a J1 program image from a UART byte stream into program RAM.
// Stream is count (LE), N words low byte first, then an XOR checksum; the CPU stays in reset until the image checks out.
module j1_boot_loader #(
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        boot_req_i,
    output logic        cpu_rst_o,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [1:0]  E_NONE    = 2'd0;
    localparam logic [1:0]  E_COUNT   = 2'd1;
    localparam logic [1:0]  E_CSUM    = 2'd2;
    localparam logic [1:0]  E_TIMEOUT = 2'd3;
    localparam logic [23:0] TMO_LAST  = TIMEOUT - 24'd1;
    localparam logic [15:0] MAX_WORDS = 16'd8192;

    state_t      r_state;
    logic        r_rx_ready;
    logic        r_cpu_rst;
    logic        r_ram_we;
    logic [12:0] r_ram_addr;
    logic [15:0] r_ram_wdata;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [7:0]  r_cnt_lo;
    logic [7:0]  r_dat_lo;
    logic [7:0]  r_xor;
    logic [13:0] r_nwords;
    logic [13:0] r_idx;
    logic [23:0] r_tmo;

    state_t      w_state_nxt;
    logic [1:0]  w_code_nxt;
    logic        w_xfer;
    logic        w_timed;
    logic        w_tmo_hit;
    logic        w_last_word;
    logic [15:0] w_count;

    function automatic logic is_rx_state(input state_t s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DAT_LO) ||
               (s == S_DAT_HI) || (s == S_CSUM);
    endfunction

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_count     = {rx_data, r_cnt_lo};
    assign w_timed     = is_rx_state(r_state) && (r_state != S_CNT_LO);
    assign w_tmo_hit   = w_timed && (r_tmo == TMO_LAST);
    // Index is 14 bits so the compare against N=8192 never aliases.
    assign w_last_word = (r_idx + 14'd1) == r_nwords;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_err_code;
        if (boot_req_i) begin
            w_state_nxt = S_CNT_LO;
            w_code_nxt  = E_NONE;
        end else begin
            case (r_state)
                S_CNT_LO: begin
                    if (w_xfer) w_state_nxt = S_CNT_HI;
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        if ((w_count != 16'd0) && (w_count <= MAX_WORDS)) begin
                            w_state_nxt = S_DAT_LO;
                        end else begin
                            w_state_nxt = S_ERR;
                            w_code_nxt  = E_COUNT;
                        end
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = E_TIMEOUT;
                    end
                end
                S_DAT_LO: begin
                    if (w_xfer) begin
                        w_state_nxt = S_DAT_HI;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = E_TIMEOUT;
                    end
                end
                S_DAT_HI: begin
                    if (w_xfer) begin
                        w_state_nxt = w_last_word ? S_CSUM : S_DAT_LO;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = E_TIMEOUT;
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        if (rx_data == r_xor) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_state_nxt = S_ERR;
                            w_code_nxt  = E_CSUM;
                        end
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = E_TIMEOUT;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state     <= S_CNT_LO;
            r_rx_ready  <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 13'd0;
            r_ram_wdata <= 16'd0;
            r_err       <= 1'b0;
            r_err_code  <= E_NONE;
            r_cnt_lo    <= 8'd0;
            r_dat_lo    <= 8'd0;
            r_xor       <= 8'd0;
            r_nwords    <= 14'd0;
            r_idx       <= 14'd0;
            r_tmo       <= 24'd0;
        end else begin
            // Status outputs are registered copies of the next state.
            r_state    <= w_state_nxt;
            r_rx_ready <= is_rx_state(w_state_nxt);
            r_cpu_rst  <= (w_state_nxt != S_RUN);
            r_err      <= (w_state_nxt == S_ERR);
            r_err_code <= (w_state_nxt == S_ERR) ? w_code_nxt : E_NONE;
            r_ram_we   <= 1'b0;

            if (boot_req_i) begin
                r_idx <= 14'd0;
                r_xor <= 8'd0;
                r_tmo <= 24'd0;
            end else begin
                if (w_xfer || (w_state_nxt != r_state) || !w_timed) begin
                    r_tmo <= 24'd0;
                end else begin
                    r_tmo <= r_tmo + 24'd1;
                end

                if (w_xfer) begin
                    case (r_state)
                        S_CNT_LO: r_cnt_lo <= rx_data;
                        S_CNT_HI: r_nwords <= w_count[13:0];
                        S_DAT_LO: begin
                            r_dat_lo <= rx_data;
                            r_xor    <= r_xor ^ rx_data;
                        end
                        S_DAT_HI: begin
                            r_xor       <= r_xor ^ rx_data;
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= r_idx[12:0];
                            r_ram_wdata <= {rx_data, r_dat_lo};
                            r_idx       <= r_idx + 14'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign busy_o     = r_rx_ready;
    assign cpu_rst_o  = r_cpu_rst;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;

endmodule

// File: tb/tb_j1_boot_loader.sv
// tb_j1_boot_loader: randomized image loads against a word-list/XOR model of the loader.
module tb_j1_boot_loader;

    localparam logic [23:0] TMO = 24'd16;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_n_i;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_req_i;
    logic        cpu_rst_o;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_chk  = 0;
    int n_fail = 0;
    int viol   = 0;
    logic [28:0] wr_q[$];
    logic [15:0] src_words[$];

    j1_boot_loader #(.TIMEOUT(TMO)) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .boot_req_i  (boot_req_i),
        .cpu_rst_o   (cpu_rst_o),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // Every RAM write seen on the bus, plus writes made while the CPU was out of reset.
    always @(negedge sys_clk_i) begin
        if (ram_we) begin
            wr_q.push_back({ram_addr, ram_wdata});
            if (!cpu_rst_o) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int n;
        repeat ($urandom_range(0, maxgap)) @(negedge sys_clk_i);
        @(negedge sys_clk_i);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge sys_clk_i);
            n++;
        end
        if (n >= 20) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge sys_clk_i);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_boot(input bit with_valid);
        @(negedge sys_clk_i);
        boot_req_i = 1'b1;
        if (with_valid) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge sys_clk_i);
        boot_req_i = 1'b0;
        rx_valid   = 1'b0;
        chk("boot_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("boot_rx_ready", 32'(rx_ready), 32'd1);
        chk("boot_err", 32'(err_o), 32'd0);
        chk("boot_code", 32'(err_code_o), 32'd0);
    endtask

    task automatic check_reset_outs();
        chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
    endtask

    task automatic check_status(input logic [1:0] code);
        chk("err_code", 32'(err_code_o), 32'(code));
        chk("err_o", 32'(err_o), 32'(code != 2'd0));
        chk("cpu_rst", 32'(cpu_rst_o), 32'(code != 2'd0));
        chk("rx_ready_end", 32'(rx_ready), 32'd0);
        chk("busy_end", 32'(busy_o), 32'd0);
    endtask

    // Model: a valid count yields exactly the N words at addresses 0..N-1; outcome from count range and XOR.
    task automatic run_case(input logic [15:0] nf, input logic [7:0] csum_mask,
                            input int maxgap, input bit boot_first);
        logic [7:0]  x;
        logic [15:0] w;
        logic [15:0] words[$];
        logic [1:0]  exp_code;
        bit          cnt_ok;
        int          base;
        int          vbase;
        int          nbad;
        if (boot_first) do_boot(1'b0);
        base   = wr_q.size();
        vbase  = viol;
        cnt_ok = (nf >= 16'd1) && (nf <= 16'd8192);
        send_byte(nf[7:0], maxgap);
        send_byte(nf[15:8], maxgap);
        if (cnt_ok) begin
            x = 8'd0;
            for (int i = 0; i < int'(nf); i++) begin
                w = (src_words.size() > 0) ? src_words.pop_front() : 16'($urandom);
                words.push_back(w);
                x = x ^ w[7:0] ^ w[15:8];
                send_byte(w[7:0], maxgap);
                send_byte(w[15:8], maxgap);
            end
            send_byte(x ^ csum_mask, maxgap);
        end
        idle(4);
        exp_code = !cnt_ok ? 2'd1 : ((csum_mask != 8'd0) ? 2'd2 : 2'd0);
        chk("wr_count", 32'(wr_q.size() - base), 32'(words.size()));
        nbad = 0;
        for (int i = 0; i < words.size() && (base + i) < wr_q.size(); i++) begin
            if (wr_q[base + i] !== {13'(i), words[i]}) nbad++;
        end
        chk("wr_content", 32'(nbad), 32'd0);
        chk("cpu_out_of_rst_on_we", 32'(viol - vbase), 32'd0);
        check_status(exp_code);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        rx_valid    = 1'b0;
        rx_data     = 8'd0;
        boot_req_i  = 1'b0;
        sys_rst_n_i = 1'b1;
        #2 sys_rst_n_i = 1'b0;
        #1 check_reset_outs();
        idle(3);
        sys_rst_n_i = 1'b1;
        #1 chk("rel_rx_ready_before_edge", 32'(rx_ready), 32'd0);
        @(negedge sys_clk_i);
        chk("rel_rx_ready_after_edge", 32'(rx_ready), 32'd1);
        chk("rel_busy_after_edge", 32'(busy_o), 32'd1);

        // CNT_LO waits forever for the first byte.
        idle(40);
        chk("cnt_lo_no_timeout", 32'(err_o), 32'd0);

        // Two-word image 1234h, 5678h.
        src_words.push_back(16'h1234);
        src_words.push_back(16'h5678);
        run_case(16'd2, 8'h00, 0, 1'b0);

        // Count out of range.
        run_case(16'd0, 8'h00, 1, 1'b1);
        run_case(16'd8193, 8'h00, 1, 1'b1);

        // Word 55AAh with checksum 00 instead of FF.
        src_words.push_back(16'h55AA);
        run_case(16'd1, 8'hFF, 0, 1'b1);

        // Inter-byte timeout after the AA low byte.
        do_boot(1'b0);
        base = wr_q.size();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        cyc = 0;
        while (!err_o && cyc < 100) begin
            @(negedge sys_clk_i);
            cyc++;
        end
        chk("tmo_cycles", 32'(cyc), 32'd16);
        chk("tmo_code", 32'(err_code_o), 32'd3);
        chk("tmo_cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("tmo_no_write", 32'(wr_q.size() - base), 32'd0);

        // Reload requested from RUN with a byte on the bus.
        run_case(16'd3, 8'h00, 1, 1'b1);
        do_boot(1'b1);
        run_case(16'd4, 8'h00, 2, 1'b0);

        // Reload requested mid-image while a byte is being accepted.
        do_boot(1'b0);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        do_boot(1'b1);
        run_case(16'd3, 8'h00, 1, 1'b0);

        // Randomized images, corrupted checksums and bad counts.
        for (int t = 0; t < 24; t++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            if (sel == 0) begin
                run_case(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(8193, 65535)),
                         8'h00, 2, 1'b1);
            end else begin
                run_case(16'($urandom_range(1, 6)),
                         (sel == 1) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00, 3, 1'b1);
            end
        end

        // Asynchronous reset in the middle of an image.
        do_boot(1'b0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        chk("pre_rst_wdata", 32'(ram_wdata), 32'h2211);
        #2 sys_rst_n_i = 1'b0;
        #1 check_reset_outs();
        base     = wr_q.size();
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        idle(3);
        rx_valid    = 1'b0;
        sys_rst_n_i = 1'b1;
        idle(5);
        chk("rst_no_write", 32'(wr_q.size() - base), 32'd0);
        chk("rst_rel_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_rel_cpu_rst", 32'(cpu_rst_o), 32'd1);
        run_case(16'd2, 8'h00, 1, 1'b0);

        // Largest legal image: every address 0..8191 written once.
        run_case(16'd8192, 8'h00, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
